// File: rtl/sevenseg_pkg.sv
// Shared constants and hex decode table for the seven-segment display drivers.
// Segment vectors are active-low and written g..a (bit 6 = g, bit 0 = a).
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

  typedef logic [SEG_W-1:0]      seg_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [NUM_DIGITS-1:0] an_t;
  typedef logic [NIB_W-1:0]      nib_t;
  typedef logic [VAL_W-1:0]      val_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam an_t  AN_OFF    = 4'hF;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic seg_t hex_decode(input nib_t nib);
    return HEX_TABLE[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Value/load/enable inputs and pin-level outputs of the scanned display driver.
interface sevenseg_scan_driver_if;
  import sevenseg_pkg::*;

  val_t                  value;
  logic                  load;
  logic [NUM_DIGITS-1:0] digit_en;
  seg_t                  seg;
  an_t                   an;
  idx_t                  digit_idx;
  logic                  frame_done;

  modport master (
    output value, load, digit_en,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  value, load, digit_en,
    output seg, an, digit_idx, frame_done
  );

endinterface

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_sevenseg
  import sevenseg_pkg::*;
(
  input  nib_t nib,
  output seg_t seg_c
);

  assign seg_c = hex_decode(nib);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with post-advance blanking
// and value updates deferred to the 3->0 frame wrap.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DIGIT_HZ     = 4000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  sevenseg_scan_driver_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / DIGIT_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [PW-1:0] PRE_MAX    = PW'(DIV - 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);
  localparam idx_t          IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0] pre_q,   pre_d;
  idx_t          idx_q,   idx_d;
  logic [BW-1:0] blank_q, blank_d;
  val_t          disp_q,  disp_d;
  val_t          pend_q,  pend_d;
  logic          pv_q,    pv_d;
  seg_t          seg_q,   seg_d;
  an_t           an_q,    an_d;
  idx_t          didx_q;
  logic          fd_q,    fd_d;

  logic tick;
  logic wrap;
  logic blanked;
  nib_t nib;
  seg_t dec_c;

  hex_to_sevenseg u_dec (
    .nib   (nib),
    .seg_c (dec_c)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      blank_q <= BLANK_INIT;
      disp_q  <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      didx_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      didx_q  <= idx_q;
      fd_q    <= fd_d;
    end
  end

  // Next-state: prescaler, scan index, blank interval and tear-free value update.
  always_comb begin
    tick    = (pre_q == PRE_MAX);
    wrap    = tick && (idx_q == IDX_LAST);
    pre_d   = tick ? '0 : pre_q + PW'(1);
    idx_d   = idx_q;
    blank_d = blank_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    fd_d    = wrap;

    if (tick) begin
      idx_d   = idx_q + IDX_W'(1);
      blank_d = BLANK_INIT;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BW'(1);
    end

    // A load landing on the wrap bypasses pend; any older pending value is dropped.
    if (bus.load) begin
      if (wrap) begin
        disp_d = bus.value;
        pv_d   = 1'b0;
      end else begin
        pend_d = bus.value;
        pv_d   = 1'b1;
      end
    end else if (wrap && pv_q) begin
      disp_d = pend_q;
      pv_d   = 1'b0;
    end
  end

  // Pin values for the digit currently selected by idx_q.
  always_comb begin
    nib     = disp_q[{idx_q, 2'b00} +: NIB_W];
    blanked = (blank_q != '0) || !bus.digit_en[idx_q];
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    if (!blanked) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dec_c;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = didx_q;
  assign bus.frame_done = fd_q;

endmodule
